// File: rtl/ex_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Restoring division, one quotient bit per cycle, with a pipeline stall request.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  wd_i,
  input  logic        annul_i,
  output logic        stall_req_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  wd_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [4:0]  count_r;
  logic        sel_rem_r;
  logic        neg_quo_r;
  logic        neg_rem_r;
  logic [4:0]  wd_r;
  logic [32:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvsr_r;
  logic        ready_r;
  logic [31:0] result_r;
  logic [4:0]  wd_out_r;

  logic        is_signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic        div_zero_s;
  logic        ovf_s;
  logic        accept_s;
  logic [31:0] special_res_s;
  logic [32:0] rem_shift_s;
  logic [31:0] quo_shift_s;
  logic [32:0] rem_nx_s;
  logic [31:0] quo_nx_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] fin_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // op_i[1] selects remainder, op_i[0] selects unsigned
  assign is_signed_s = ~op_i[0];
  assign a_neg_s     = is_signed_s & dividend_i[31];
  assign b_neg_s     = is_signed_s & divisor_i[31];
  assign div_zero_s  = (divisor_i == 32'd0);
  assign ovf_s       = is_signed_s & (dividend_i == 32'h8000_0000) &
                       (divisor_i == 32'hFFFF_FFFF);
  assign accept_s    = start_i & ~annul_i;

  assign stall_req_o = ~rst & (((state_r == IDLE) & accept_s) | (state_r == CALC));
  assign ready_o     = ready_r & ~annul_i & ~rst;
  assign result_o    = result_r;
  assign wd_o        = wd_out_r;

  // Result for divide-by-zero and signed overflow, resolved without iterating
  always_comb begin
    special_res_s = 32'd0;
    if (div_zero_s) begin
      special_res_s = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
    end else begin
      special_res_s = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring-division step plus the final sign correction
  always_comb begin
    rem_shift_s = {rem_r[31:0], quo_r[31]};
    quo_shift_s = {quo_r[30:0], 1'b0};
    rem_nx_s    = rem_shift_s;
    quo_nx_s    = quo_shift_s;
    if (rem_shift_s >= {1'b0, dvsr_r}) begin
      rem_nx_s = rem_shift_s - {1'b0, dvsr_r};
      quo_nx_s = quo_shift_s | 32'd1;
    end else begin
      rem_nx_s = rem_shift_s;
      quo_nx_s = quo_shift_s;
    end
    quo_fix_s = neg_quo_r ? neg32(quo_nx_s) : quo_nx_s;
    rem_fix_s = neg_rem_r ? neg32(rem_nx_s[31:0]) : rem_nx_s[31:0];
    fin_s     = sel_rem_r ? rem_fix_s : quo_fix_s;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= 5'd0;
      sel_rem_r <= 1'b0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      wd_r      <= 5'd0;
      rem_r     <= 33'd0;
      quo_r     <= 32'd0;
      dvsr_r    <= 32'd0;
      ready_r   <= 1'b0;
      result_r  <= 32'd0;
      wd_out_r  <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          if (accept_s) begin
            if (div_zero_s || ovf_s) begin
              result_r <= special_res_s;
              wd_out_r <= wd_i;
              ready_r  <= 1'b1;
              state_r  <= DONE;
            end else begin
              sel_rem_r <= op_i[1];
              wd_r      <= wd_i;
              neg_quo_r <= a_neg_s ^ b_neg_s;
              neg_rem_r <= a_neg_s;
              rem_r     <= 33'd0;
              quo_r     <= a_neg_s ? neg32(dividend_i) : dividend_i;
              dvsr_r    <= b_neg_s ? neg32(divisor_i) : divisor_i;
              count_r   <= 5'd0;
              state_r   <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (annul_i) begin
            count_r <= 5'd0;
            state_r <= IDLE;
          end else begin
            rem_r   <= rem_nx_s;
            quo_r   <= quo_nx_s;
            count_r <= count_r + 5'd1;
            if (count_r == 5'd31) begin
              result_r <= fin_s;
              wd_out_r <= wd_r;
              ready_r  <= 1'b1;
              state_r  <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
        end
        DONE: begin
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          count_r <= 5'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative RV32M divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It takes the registered operands, destination address and divide opcode from ID/EX and computes DIV/DIVU/REM/REMU one quotient bit per cycle. While a divide is in progress it raises a combinational stall request that freezes IF/ID/EX. It then presents the result and destination for one cycle to the EX/MEM write-back path.

## Interface
- No parameters; data width fixed at 32, register address width at 5.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  EX-stage operation is a divide; level, sampled only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- dividend_i  in  32  rs1 value (from ID/EX reg1).
- divisor_i  in  32  rs2 value (from ID/EX reg2).
- wd_i  in  5  destination register address.
- annul_i  in  1  flush or cancel; highest priority after rst.
- stall_req_o  out  1  combinational; holds the pipeline.
- ready_o  out  1  result valid this cycle.
- result_o  out  32  quotient or remainder, registered.
- wd_o  out  5  destination captured at start, registered.

## Operation
- States:
  - IDLE: start accepted here; if divisor_i == 0 or signed overflow, go to DONE; otherwise latch operands and go to CALC with count = 0.
  - CALC: one iteration per cycle; count 31 -> DONE.
  - DONE: ready_o high; unconditionally -> IDLE next edge.
- Latch at start: op, wd_i, sign flags, magnitudes.
  - Signed ops (DIV/REM): magnitude = two's-complement absolute value.
  - Unsigned ops: magnitude = raw value.
- Restoring division per CALC cycle:
  - rem = {rem[31:0], quo[31]}, a 33-bit partial remainder; quo <<= 1.
  - If rem >= {1'b0, divisor}: rem -= divisor and quo[0] = 1.
- Sign fix on CALC -> DONE:
  - DIV: quotient negated if the dividend and divisor signs differ.
  - REM: remainder takes the dividend's sign.
  - result_o loaded with the quotient (DIV/DIVU) or remainder (REM/REMU).
- Special cases, resolved in IDLE with no CALC:
  - divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend_i (all four ops).
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- stall_req_o = (IDLE & start_i & ~annul_i) | CALC.
  - Deasserted in DONE, so the divide instruction leaves ID/EX on the DONE edge.
  - start_i while in DONE is ignored.
- annul_i:
  - In IDLE: start_i is ignored.
  - In CALC or DONE: go to IDLE at the next edge.
  - ready_o = DONE & ~annul_i; result_o and wd_o are not updated by an annulled op.
- Reset: state IDLE, count 0, ready_o 0, result_o 0, wd_o 0.
  - stall_req_o is 0 while rst is high, regardless of start_i.
  - Reset mid-CALC aborts with no ready_o.

## Timing
- Normal divide:
  - Start sampled at edge E0, stall high from the cycle before E0.
  - CALC occupies edges E1..E32; DONE is entered at E32.
  - ready_o high for exactly the one cycle after E32; total 33 cycles.
- Special case: DONE is entered at E0; ready_o is high for the one cycle after E0.
- result_o and wd_o hold their last value after DONE until the next completed op.
- Back-to-back divides: the second start is sampled in IDLE the cycle after DONE, giving a one-cycle bubble minimum.

## Test plan
- DIVU 100 / 7: stall_req_o high for 33 cycles; ready_o 1 for one cycle; result_o = 14; wd_o = start wd_i; REMU on the same operands gives 2.
- DIV 0xFFFFFFF9 (-7) / 2: result_o = 0xFFFFFFFD (-3). REM on the same operands: result_o = 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE: 0xFFFFFFFD.
- Divide by zero, dividend 0x12345678:
  - DIV/DIVU: result_o = 0xFFFFFFFF.
  - REM/REMU: result_o = 0x12345678.
  - ready_o in the cycle after the start edge; no CALC.
- Overflow 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000 and REM gives 0; both take one cycle. The same operands with DIVU give 0 after 33 cycles.
- annul_i pulsed at CALC count 10:
  - Next cycle: IDLE, stall_req_o 0.
  - No ready_o; result_o keeps its prior value.
  - A new DIVU 9 / 3 then completes normally with 3.
- rst asserted mid-CALC with start_i still high:
  - All outputs 0 during and after reset.
  - Next start after rst deasserts runs a full 33-cycle divide correctly.
